// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and the
// baud-period helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  // Clock cycles per serial bit (integer division, truncating).
  function automatic int unsigned uart_cycle(input int unsigned clk_mhz,
                                             input int unsigned baud);
    return (clk_mhz * 32'd1000000) / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input. The reset
// value is a parameter so idle-high lines do not see a false edge after reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: plain shift of the input through two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages, reset to the line's idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Detects the start edge, re-checks the start bit at its
// middle, samples eight data bits (LSB first) and the stop bit at bit centres,
// and hands finished bytes to a one-entry holding register.
//
// Byte interface: rx_data/rx_data_valid form a valid/ready source. A byte
// moves to the consumer on a rising clk edge where rx_data_valid and
// rx_data_ready are both 1; rx_data is held stable while rx_data_valid is 1,
// and rx_data_ready is ignored while rx_data_valid is 0. The receiver never
// waits for the consumer: a byte that completes while the holding register is
// still full is dropped and flagged on overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE   = 27,
  parameter int unsigned BAUD_RATE = 5625
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_pin,
  output logic [7:0]  rx_data,
  output logic        rx_data_valid,
  input  logic        rx_data_ready,
  output logic        frame_err,
  output logic        overrun,
  output uart_state_e dbg_state
);

  localparam int unsigned CYCLE = uart_cycle(CLK_FRE, BAUD_RATE);
  localparam int unsigned HALF  = CYCLE / 2;

  localparam logic [31:0] CYCLE_LAST = 32'(CYCLE - 1);
  localparam logic [31:0] HALF_LAST  = 32'(HALF - 1);
  localparam logic [2:0]  BIT_LAST   = 3'(DATA_BITS - 1);

  // Fewer than 8 clocks per bit leaves no room for the synchronizer delay
  // and mid-bit sampling.
  if (CYCLE < 8) begin : g_cycle_too_small
    $error("uart_rx: CLK_FRE/BAUD_RATE give fewer than 8 clocks per bit");
  end

  logic rx_s;
  logic rx_d_q, rx_d_d;
  logic start_edge;

  uart_state_e state_q, state_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        deliver_q, deliver_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_pin),
    .q     (rx_s)
  );

  assign start_edge = rx_d_q & ~rx_s;

  // Frame FSM: start-edge detection, bit timing, sampling, stop check.
  always_comb begin
    rx_d_d      = rx_s;
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d     = S_START;
          cycle_cnt_d = 32'd0;
        end
      end
      S_START: begin
        if (cycle_cnt_q == HALF_LAST) begin
          cycle_cnt_d = 32'd0;
          if (rx_s) begin
            // Line went back high before mid-start: a glitch, not a frame.
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (cycle_cnt_q == CYCLE_LAST) begin
          cycle_cnt_d        = 32'd0;
          shift_d[bit_cnt_q] = rx_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (cycle_cnt_q == CYCLE_LAST) begin
          // Back to idle at mid-stop so a following start edge is caught
          // even when the sender's bit period runs slightly short.
          cycle_cnt_d = 32'd0;
          state_d     = S_IDLE;
          if (rx_s) deliver_d   = 1'b1;
          else      frame_err_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cycle_cnt_d = 32'd0;
      end
    endcase
  end

  // Holding register: load a finished byte, drop it on overrun, clear on accept.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (deliver_q) begin
      if (!rx_valid_q || rx_data_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_data_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d_q      <= 1'b1;
      state_q     <= S_IDLE;
      cycle_cnt_q <= 32'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
    end else begin
      rx_d_q      <= rx_d_d;
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      deliver_q   <= deliver_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_data_valid = rx_valid_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven bit by bit, checked against a
// frame-level model of the holding register (held byte, overrun and
// framing-error counts, accepted-byte queue).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_MHZ = 1;
  localparam int BAUD    = 10000;
  localparam int CYC     = CLK_MHZ * 1000000 / BAUD;  // 100 clocks per bit

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_pin;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic        frame_err;
  logic        overrun;
  uart_state_e dbg_state;

  uart_rx #(.CLK_FRE(CLK_MHZ), .BAUD_RATE(BAUD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_pin        (rx_pin),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .dbg_state     (dbg_state)
  );

  // Clock / pulse monitor
  always #5 clk = ~clk;

  int cyc    = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int fe_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (overrun) ov_cnt <= ov_cnt + 1;
  end

  // Scoreboard and model
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_held;
  logic       m_held_v = 1'b0;
  int         m_fe = 0;
  int         m_ov = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Driver: one frame starting at the current negedge. Returns observations
  // taken one clock before the end of the stop bit.
  task automatic run_frame(input logic [7:0] data, input logic stop_bit, input int period,
                           input logic accept, input int gap,
                           output int obs_fe, output int obs_ov,
                           output logic obs_valid, output logic [7:0] obs_data);
    int fe0, ov0, start;
    logic was_held;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    start = cyc;
    rx_pin = 1'b0;
    repeat (period) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = data[i];
      repeat (period) @(negedge clk);
    end
    rx_pin = stop_bit;
    repeat (period - 1) @(negedge clk);
    // Model update for this frame.
    was_held = m_held_v;
    if (stop_bit) begin
      if (m_held_v) m_ov++;
      else begin
        m_held   = data;
        m_held_v = 1'b1;
      end
    end else begin
      m_fe++;
    end
    obs_fe = fe_cnt - fe0;
    obs_ov = ov_cnt - ov0;
    obs_valid = rx_data_valid;
    obs_data = rx_data;
    check("frame_err_pulses", 32'(obs_fe), stop_bit ? 32'd0 : 32'd1);
    check("overrun_pulses", 32'(obs_ov), (stop_bit && was_held) ? 32'd1 : 32'd0);
    if (!stop_bit) begin
      checks++;
      if (fe_cyc - start < CYC * 19 / 2 || fe_cyc - start > CYC * 19 / 2 + 8) begin
        errors++;
        $display("FAIL frame_err_timing: got %0d cycles after start, expected about %0d",
                 fe_cyc - start, CYC * 19 / 2);
      end
    end
    check("valid_end_of_frame", 32'(rx_data_valid), 32'(m_held_v));
    if (m_held_v) check("data_end_of_frame", 32'(rx_data), 32'(m_held));
    // Consumer accepts for one clock at the end of the stop bit.
    if (accept) begin
      rx_data_ready = 1'b1;
      if (m_held_v) begin
        exp_q.push_back(m_held);
        m_held_v = 1'b0;
      end
      if (rx_data_valid) begin
        if (exp_q.size() == 0) check("unexpected_accept", 32'(rx_data), 32'hFFFF_FFFF);
        else check("accepted_byte", 32'(rx_data), 32'(exp_q.pop_front()));
      end else if (exp_q.size() != 0) begin
        check("missing_accept", 32'(rx_data_valid), 32'd1);
        void'(exp_q.pop_front());
      end
    end
    @(negedge clk);
    rx_data_ready = 1'b0;
    if (accept) check("valid_after_accept", 32'(rx_data_valid), 32'd0);
    rx_pin = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         period;
    logic       accept;
    int         gap;
    int         exp_fe;
    int         exp_ov;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int         o_fe, o_ov;
    logic       o_valid;
    logic [7:0] o_data;
    int         fe0, ov0;
    logic       saw_data;

    // Clock / reset block
    rst_n = 1'b0;
    rx_pin = 1'b1;
    rx_data_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(rx_data_valid), 32'd0);
    check("reset_data", 32'(rx_data), 32'h00);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(S_IDLE));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Directed frame table
    vecs[0] = '{8'hA5, 1'b1, CYC,     1'b1, 10, 0, 0, 1'b1, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, CYC,     1'b0, 0,  0, 0, 1'b1, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, CYC,     1'b1, 10, 0, 1, 1'b1, 8'h00};
    vecs[3] = '{8'h3C, 1'b0, CYC,     1'b1, 10, 1, 0, 1'b0, 8'h00};
    vecs[4] = '{8'h81, 1'b1, CYC,     1'b1, 10, 0, 0, 1'b1, 8'h81};
    vecs[5] = '{8'h55, 1'b1, CYC + 3, 1'b1, 10, 0, 0, 1'b1, 8'h55};
    vecs[6] = '{8'h55, 1'b1, CYC - 3, 1'b1, 10, 0, 0, 1'b1, 8'h55};
    vecs[7] = '{8'hE7, 1'b1, CYC,     1'b0, 5,  0, 0, 1'b1, 8'hE7};
    for (int v = 0; v < 8; v++) begin
      run_frame(vecs[v].data, vecs[v].stop_bit, vecs[v].period, vecs[v].accept, vecs[v].gap,
                o_fe, o_ov, o_valid, o_data);
      check($sformatf("vec%0d_frame_err", v), 32'(o_fe), 32'(vecs[v].exp_fe));
      check($sformatf("vec%0d_overrun", v), 32'(o_ov), 32'(vecs[v].exp_ov));
      check($sformatf("vec%0d_valid", v), 32'(o_valid), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_data", v), 32'(o_data), 32'(vecs[v].exp_data));
    end

    // Glitch shorter than half a bit: must not start a frame.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    saw_data = 1'b0;
    rx_pin = 1'b0;
    repeat (CYC / 4) @(negedge clk);
    rx_pin = 1'b1;
    repeat (2 * CYC) begin
      @(negedge clk);
      if (dbg_state == S_DATA || dbg_state == S_STOP) saw_data = 1'b1;
    end
    check("glitch_no_data_state", 32'(saw_data), 32'd0);
    check("glitch_state_idle", 32'(dbg_state), 32'(S_IDLE));
    check("glitch_flags", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);
    check("glitch_valid", 32'(rx_data_valid), 32'(m_held_v));
    check("glitch_data", 32'(rx_data), 32'hE7);

    // Break: line held low for well over a frame.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx_pin = 1'b0;
    repeat (15 * CYC) @(negedge clk);
    rx_pin = 1'b1;
    repeat (20) @(negedge clk);
    m_fe++;
    check("break_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("break_overrun", 32'(ov_cnt - ov0), 32'd0);
    check("break_data_kept", 32'(rx_data), 32'hE7);

    // Reset during bit 4 of 8'hC3 while a byte is held.
    rx_pin = 1'b0;
    repeat (CYC) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_pin = vecs[0].data[i] ^ vecs[0].data[i] ^ ((8'hC3 >> i) & 8'h01) != 0;
      repeat (CYC) @(negedge clk);
    end
    rx_pin = 1'b0;
    repeat (CYC / 2) @(negedge clk);
    rst_n = 1'b0;
    rx_pin = 1'b1;
    #1;
    check("midreset_valid", 32'(rx_data_valid), 32'd0);
    check("midreset_data", 32'(rx_data), 32'h00);
    check("midreset_frame_err", 32'(frame_err), 32'd0);
    check("midreset_overrun", 32'(overrun), 32'd0);
    check("midreset_state", 32'(dbg_state), 32'(S_IDLE));
    m_held_v = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run_frame(8'h12, 1'b1, CYC, 1'b1, 10, o_fe, o_ov, o_valid, o_data);
    check("post_reset_data", 32'(o_data), 32'h12);

    // Randomized frames: data, stop bit, baud drift, gaps, acceptance.
    for (int n = 0; n < 16; n++) begin
      logic [7:0] d;
      logic       s, a;
      int         p, g;
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 5) != 0);
      p = CYC - 3 + $urandom_range(0, 6);
      a = ($urandom_range(0, 2) != 0);
      g = s ? $urandom_range(0, 20) : 4 + $urandom_range(0, 20);
      run_frame(d, s, p, a, g, o_fe, o_ov, o_valid, o_data);
    end

    // Final report
    repeat (2 * CYC) @(negedge clk);
    check("pending_accepts", 32'(exp_q.size()), 32'd0);
    check("total_frame_err", 32'(fe_cnt), 32'(m_fe));
    check("total_overrun", 32'(ov_cnt), 32'(m_ov));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the downstream counterpart of the team's UART transmitter.
- Consumes an 8N1 serial stream (idle high, start 0, 8 data bits LSB first, stop 1) on rx_pin.
- Presents each byte on a valid/ready byte interface to the host-side logic (command parser / RX FIFO).
- Same baud-counter scheme and parameters as the transmitter, so a transmitter's tx_pin can be wired directly to rx_pin.

Parameters:
- CLK_FRE, 27, clock frequency in MHz.
- BAUD_RATE, 5625, serial baud rate in bit/s.
- Derived localparam CYCLE = CLK_FRE*1000000/BAUD_RATE, integer division (4800 at defaults). Elaboration must fail if CYCLE < 8.
- Derived localparam HALF = CYCLE/2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- rx_pin  input  1  asynchronous serial input.
- rx_data  output  8  received byte, stable while rx_data_valid is 1.
- rx_data_valid  output  1  byte available.
- rx_data_ready  input  1  consumer accepts the byte when valid and ready are both 1 on a rising clk edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: new byte completed while previous byte still unaccepted.

Behaviour:
- Reset values: rx_data = 8'h00, rx_data_valid = 0, frame_err = 0, overrun = 0.
- Reset state: synchronizer flops = 1, state = S_IDLE, counters = 0.
- Reset mid-frame aborts the frame immediately; no output is produced for it.
- Input sync: rx_pin passes through a 2-flop synchronizer (rx_s), then one more flop (rx_d) for edge detection. Start edge = rx_d==1 && rx_s==0.
- cycle_cnt is 32 bit. It clears on every state change and after every data-bit sample; otherwise it increments.
- S_IDLE: on start edge -> S_START.
- S_START: wait until cycle_cnt == HALF-1, then sample rx_s at mid-start-bit.
  - Sample 1: glitch; -> S_IDLE, no flags.
  - Sample 0: -> S_DATA, bit_cnt = 0.
- S_DATA: at cycle_cnt == CYCLE-1, sample rx_s into shift[bit_cnt] (LSB first) and increment bit_cnt.
  - Sampling of bit 7 -> S_STOP.
- S_STOP: at cycle_cnt == CYCLE-1 (mid-stop-bit), sample rx_s, then -> S_IDLE in the same edge.
  - The receiver is ready for the next start edge from mid-stop onward, which tolerates back-to-back frames and up to half a bit of baud drift.
  - Stop sample 0: frame_err pulses 1 the following cycle; the byte is discarded and rx_data/rx_data_valid are unchanged.
  - Stop sample 1: the byte is delivered on the following edge (see output register).
- Output register (holding register, separate from shift register):
  - Delivery when rx_data_valid==0, or when valid==1 and ready==1 in that same cycle: rx_data <= shift, rx_data_valid <= 1.
  - Delivery when valid==1 and ready==0: the new byte is dropped, the old byte is kept, and overrun pulses 1 for one cycle.
  - Acceptance (valid && ready) with no delivery that cycle: rx_data_valid <= 0.
  - Latency: rx_data_valid rises 1 clk after the mid-stop sample edge.
  - rx_data_ready is don't-care while valid==0.
- Receiving continues regardless of rx_data_ready. The receiver never stalls the line.
- Break (rx held 0): frame reads 8'h00 with stop=0, so frame_err pulses. The line is then idle-low with no 1->0 edge, so no further frames occur until rx returns high and falls again.

Decomposition:
- Shared package uart_pkg, used by transmitter and receiver:
  - State encodings S_IDLE/S_START/S_DATA/S_STOP.
  - Constant function uart_cycle(clk_mhz, baud).
  - DATA_BITS = 8.
- One natural sub-module: uart_sync2, a parameterizable-reset-value 2-flop synchronizer (reset value 1 here). It is reusable for other async inputs.

Test Plan:
- Single byte: transmitter at defaults sends 8'hA5 into rx_pin, ready held 1 -> one rx_data_valid pulse with rx_data=8'hA5; frame_err=0, overrun=0.
- Back-to-back with backpressure: send 8'h00 then 8'hFF with no idle gap, ready held 0 -> first byte 8'h00 held valid; overrun pulses once at the second byte's stop; after ready=1, one acceptance and valid drops, rx_data remains 8'h00.
- Framing error: drive 8'h3C with stop bit 0 -> frame_err one-cycle pulse about 9.5*CYCLE after the start edge; rx_data_valid stays 0. A following good 8'h81 frame is received correctly.
- Glitch rejection: rx_pin low for HALF/2 = 1200 cycles, then high -> no state leaves S_IDLE beyond S_START, no valid, no flags.
- Baud tolerance: send 8'h55 with bit period CYCLE*1.03 and CYCLE*0.97 -> rx_data=8'h55 in both cases.
- Reset mid-frame: assert rst_n=0 during bit 4 of 8'hC3 -> outputs return to reset values immediately; after release the next full frame 8'h12 is received correctly.
